// File: rtl/bri_pulse_seq.sv
// Bridge RF pulse sequencer: reset, excitation and echo pulses with
// turn, energy-dump and receive windows between them.
module bri_pulse_seq (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  half_period,
  input  logic [15:0] pulse_len,
  input  logic [7:0]  turn_len,
  input  logic [15:0] dump_len,
  input  logic [15:0] gap_len,
  input  logic [11:0] echo_num,
  output logic        reset_out,
  output logic        pluse_start,
  output logic        phase_ctr,
  output logic        tetw_pluse,
  output logic        turn_delay,
  output logic        dump_start,
  output logic        dumpoff_ctr,
  output logic        off_test,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_DUMP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  function automatic logic [15:0] dec16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  function automatic logic [7:0] dec8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  logic [2:0]  state, nxt_state;
  logic [15:0] cnt, nxt_cnt;
  logic [11:0] echo_idx, nxt_echo;
  logic [7:0]  hcnt, nxt_hcnt;
  logic        nxt_phase;

  // Latched configuration, stored as (length - 1) with 0 treated as 1
  logic [7:0]  c_hp;
  logic [15:0] c_pulse;
  logic [15:0] c_turn;
  logic [15:0] c_dump;
  logic [15:0] c_gap;
  logic [11:0] c_echo;

  logic load;

  assign load = (state == S_IDLE) && start && !abort;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_echo  = echo_idx;
    nxt_hcnt  = hcnt;
    nxt_phase = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          nxt_state = S_RST;
          nxt_cnt   = 16'd3;
          nxt_echo  = 12'd0;
        end
      end
      S_RST: begin
        if (cnt == 16'd0) begin
          nxt_state = S_PULSE;
          nxt_cnt   = c_pulse;
          nxt_hcnt  = c_hp;
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      S_PULSE: begin
        if (cnt == 16'd0) begin
          nxt_state = S_TURN;
          nxt_cnt   = c_turn;
        end else begin
          nxt_cnt = cnt - 16'd1;
          if (hcnt == 8'd0) begin
            nxt_phase = ~phase_ctr;
            nxt_hcnt  = c_hp;
          end else begin
            nxt_phase = phase_ctr;
            nxt_hcnt  = hcnt - 8'd1;
          end
        end
      end
      S_TURN: begin
        if (cnt == 16'd0) begin
          nxt_state = S_DUMP;
          nxt_cnt   = c_dump;
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      S_DUMP: begin
        if (cnt == 16'd0) begin
          nxt_state = S_WAIT;
          nxt_cnt   = c_gap;
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      S_WAIT: begin
        if (cnt != 16'd0) begin
          nxt_cnt = cnt - 16'd1;
        end else if (echo_idx == c_echo) begin
          nxt_state = S_FIN;
        end else begin
          nxt_state = S_PULSE;
          nxt_echo  = echo_idx + 12'd1;
          nxt_cnt   = c_pulse;
          nxt_hcnt  = c_hp;
        end
      end
      S_FIN: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
    if (abort && state != S_IDLE) begin
      nxt_state = S_IDLE;
      nxt_cnt   = 16'd0;
      nxt_echo  = 12'd0;
      nxt_hcnt  = 8'd0;
      nxt_phase = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      echo_idx    <= 12'd0;
      hcnt        <= 8'd0;
      c_hp        <= 8'd0;
      c_pulse     <= 16'd0;
      c_turn      <= 16'd0;
      c_dump      <= 16'd0;
      c_gap       <= 16'd0;
      c_echo      <= 12'd0;
      reset_out   <= 1'b0;
      pluse_start <= 1'b0;
      phase_ctr   <= 1'b0;
      tetw_pluse  <= 1'b0;
      turn_delay  <= 1'b0;
      dump_start  <= 1'b0;
      dumpoff_ctr <= 1'b0;
      off_test    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      echo_idx <= nxt_echo;
      hcnt     <= nxt_hcnt;
      if (load) begin
        c_hp    <= dec8(half_period);
        c_pulse <= dec16(pulse_len);
        c_turn  <= {8'd0, dec8(turn_len)};
        c_dump  <= dec16(dump_len);
        c_gap   <= dec16(gap_len);
        c_echo  <= echo_num;
      end
      // Outputs decoded from the next state so they line up with it
      reset_out   <= (nxt_state == S_RST);
      pluse_start <= (nxt_state == S_PULSE);
      phase_ctr   <= nxt_phase;
      tetw_pluse  <= (nxt_state == S_PULSE) && (nxt_echo == 12'd0);
      turn_delay  <= (nxt_state == S_TURN);
      dump_start  <= (nxt_state == S_DUMP);
      dumpoff_ctr <= (nxt_state == S_WAIT);
      off_test    <= (nxt_state == S_WAIT);
      busy        <= (nxt_state != S_IDLE);
      done        <= (nxt_state == S_FIN);
    end
  end

endmodule

// File: tb/tb_bri_pulse_seq.sv
// Bench for bri_pulse_seq: directed scenarios plus random traffic
// checked cycle by cycle against a timeline model.
module tb_bri_pulse_seq;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  half_period;
  logic [15:0] pulse_len;
  logic [7:0]  turn_len;
  logic [15:0] dump_len;
  logic [15:0] gap_len;
  logic [11:0] echo_num;
  logic        reset_out, pluse_start, phase_ctr, tetw_pluse;
  logic        turn_delay, dump_start, dumpoff_ctr, off_test;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  bri_pulse_seq dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .half_period(half_period),
    .pulse_len  (pulse_len),
    .turn_len   (turn_len),
    .dump_len   (dump_len),
    .gap_len    (gap_len),
    .echo_num   (echo_num),
    .reset_out  (reset_out),
    .pluse_start(pluse_start),
    .phase_ctr  (phase_ctr),
    .tetw_pluse (tetw_pluse),
    .turn_delay (turn_delay),
    .dump_start (dump_start),
    .dumpoff_ctr(dumpoff_ctr),
    .off_test   (off_test),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a running sequence is a timeline indexed by cycles since start
  bit act = 1'b0;
  int k   = 0;
  int fin = 0;
  int m_hp, m_p, m_t, m_d, m_g, m_e;

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // bits: rst,pulse,phase,tetw,turn,dump,dumpoff,off,busy,done
  function automatic logic [9:0] exp_vec(input int kk);
    int per, j, e, r;
    logic [9:0] v;
    v = 10'b0;
    per = m_p + m_t + m_d + m_g;
    v[1] = 1'b1;
    if (kk <= 4) begin
      v[9] = 1'b1;
    end else if (kk == fin) begin
      v[0] = 1'b1;
    end else begin
      j = kk - 5;
      e = j / per;
      r = j % per;
      if (r < m_p) begin
        v[8] = 1'b1;
        v[7] = ((r / m_hp) % 2) == 1;
        v[6] = (e == 0);
      end else if (r < m_p + m_t) begin
        v[5] = 1'b1;
      end else if (r < m_p + m_t + m_d) begin
        v[4] = 1'b1;
      end else begin
        v[3] = 1'b1;
        v[2] = 1'b1;
      end
    end
    return v;
  endfunction

  always @(posedge clk_sys) begin
    if (!rst_n) begin
      act = 1'b0;
    end else if (act) begin
      if (abort || k == fin) act = 1'b0;
      else k++;
    end else if (start && !abort) begin
      m_hp = nz(int'(half_period));
      m_p  = nz(int'(pulse_len));
      m_t  = nz(int'(turn_len));
      m_d  = nz(int'(dump_len));
      m_g  = nz(int'(gap_len));
      m_e  = int'(echo_num);
      fin  = 5 + (m_e + 1) * (m_p + m_t + m_d + m_g);
      act  = 1'b1;
      k    = 1;
    end
  end

  always @(posedge clk_sys) begin
    logic [9:0] got, exp;
    #1;
    got = {reset_out, pluse_start, phase_ctr, tetw_pluse, turn_delay,
           dump_start, dumpoff_ctr, off_test, busy, done};
    exp = act ? exp_vec(k) : 10'b0;
    chk("outs", 32'(got), 32'(exp));
    if (act && k != fin)
      chk("onehot", 32'($countones({reset_out, pluse_start, turn_delay,
                                    dump_start, dumpoff_ctr})), 32'd1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic go(input int hp, input int p, input int t, input int d,
                    input int g, input int e);
    half_period = 8'(hp);
    pulse_len   = 16'(p);
    turn_len    = 8'(t);
    dump_len    = 16'(d);
    gap_len     = 16'(g);
    echo_num    = 12'(e);
    start       = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  // Cycles from the start cycle until done is seen, bounded
  task automatic done_lat(input string tag, input int exp);
    int n;
    n = 1;
    while (!done && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    half_period = 8'd0;
    pulse_len = 16'd0;
    turn_len = 8'd0;
    dump_len = 16'd0;
    gap_len = 16'd0;
    echo_num = 12'd0;
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    go(2, 8, 3, 5, 10, 2);
    done_lat("full_lat", 83);
    cyc(3);

    go(0, 0, 0, 0, 0, 0);
    done_lat("zero_lat", 9);
    cyc(3);

    // abort in the second DUMP (cycles 16..18 after start)
    go(1, 2, 1, 3, 2, 1);
    cyc(16);
    chk("in_dump", 32'(dump_start), 32'd1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    cyc(2);
    go(1, 1, 1, 1, 1, 0);
    chk("restart", 32'(busy), 32'd1);
    cyc(12);

    // start while busy with a config change
    go(1, 4, 2, 2, 3, 1);
    cyc(5);
    half_period = 8'd7;
    pulse_len = 16'd30;
    gap_len = 16'd1;
    echo_num = 12'd5;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    done_lat("latched_lat", 27 - 6);
    cyc(3);

    // reset mid-WAIT (cycles 11..16 after start)
    go(1, 2, 2, 2, 6, 0);
    cyc(11);
    chk("in_wait", 32'(dumpoff_ctr), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("rst_idle", 32'(busy), 32'd0);
    cyc(20);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    cyc(1);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort", 32'(busy), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom % 15) == 0;
      abort       = ($urandom % 200) == 0;
      rst_n       = ($urandom % 500) != 0;
      half_period = 8'($urandom % 5);
      pulse_len   = 16'($urandom % 7);
      turn_len    = 8'($urandom % 4);
      dump_len    = 16'($urandom % 5);
      gap_len     = 16'($urandom % 7);
      echo_num    = 12'($urandom % 4);
      cyc(1);
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
